vu_bar_renderer: RTL and testbench

//  Pixel source for the VGA timing stage: turns an audio level into one vertical VU bar with a peak-hold marker.

---
 rtl/vu_bar_renderer.sv | 114 +++++++++++
 tb/tb_vu_bar_renderer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/vu_bar_renderer.sv
// Vertical VU bar pixel source: level -> bar height with peak-hold marker, RGB 3/3/2 out.
// Level and peak state only change on frame_start so a frame is always drawn from one snapshot.
module vu_bar_renderer #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int C_SIZE      = 9,
    parameter int LVL_W       = 8,
    parameter int SCALE_SHIFT = 1,
    parameter int BAR_X0      = 288,
    parameter int BAR_W       = 64,
    parameter int YEL_ROW     = 320,
    parameter int RED_ROW     = 420,
    parameter int PEAK_THICK  = 4,
    parameter int HOLD_FRAMES = 30,
    parameter int DECAY       = 4
) (
    input  logic             pixel_clock,
    input  logic             reset,
    input  logic [LVL_W-1:0] level,
    input  logic             level_valid,
    input  logic [C_SIZE:0]  h_pos,
    input  logic [C_SIZE:0]  v_pos,
    input  logic             active,
    input  logic             frame_start,
    output logic [2:0]       red,
    output logic [2:0]       green,
    output logic [1:0]       blue
);

    localparam int PW  = C_SIZE + 1;
    localparam int HCW = $clog2(HOLD_FRAMES + 1);

    localparam logic [7:0] COL_BLACK  = 8'b000_000_00;
    localparam logic [7:0] COL_WHITE  = 8'b111_111_11;
    localparam logic [7:0] COL_GREEN  = 8'b000_111_00;
    localparam logic [7:0] COL_YELLOW = 8'b111_111_00;
    localparam logic [7:0] COL_RED    = 8'b111_000_00;

    // Scaled level, clipped to the screen height; computed wide so large levels never wrap.
    function automatic logic [PW-1:0] sat_height(input logic [LVL_W-1:0] lvl);
        logic [31:0] scaled;
        scaled = 32'(lvl) << SCALE_SHIFT;
        if (scaled >= 32'(V_ACTIVE)) return PW'(V_ACTIVE);
        return PW'(scaled);
    endfunction

    // One decay step: drop by DECAY, but never below zero nor below the current bar.
    function automatic logic [PW-1:0] decay_peak(input logic [PW-1:0] peak,
                                                 input logic [PW-1:0] floor_h);
        if ({1'b0, peak} > ({1'b0, floor_h} + (PW+1)'(DECAY))) return peak - PW'(DECAY);
        return floor_h;
    endfunction

    logic [LVL_W-1:0] shadow;
    logic [PW-1:0]    bar_h;
    logic [PW-1:0]    peak_h;
    logic [HCW-1:0]   hold_cnt;
    logic [PW-1:0]    new_h;

    logic [PW-1:0]    row;
    logic [PW-1:0]    peak_lo;
    logic             in_range;
    logic             in_col;
    logic [7:0]       rgb_p0;
    logic [7:0]       rgb_p1;

    always_comb begin
        new_h    = sat_height(shadow);
        row      = PW'(V_ACTIVE - 1) - v_pos;
        in_range = (h_pos < PW'(H_ACTIVE)) && (v_pos < PW'(V_ACTIVE));
        in_col   = (h_pos >= PW'(BAR_X0)) && (h_pos < PW'(BAR_X0 + BAR_W));
        peak_lo  = (peak_h > PW'(PEAK_THICK)) ? peak_h - PW'(PEAK_THICK) : '0;
        rgb_p0   = COL_BLACK;
        if (active && in_range && in_col) begin
            if ((peak_h != '0) && (row >= peak_lo) && (row < peak_h)) begin
                rgb_p0 = COL_WHITE;
            end else if (row < bar_h) begin
                if (row < PW'(YEL_ROW))      rgb_p0 = COL_GREEN;
                else if (row < PW'(RED_ROW)) rgb_p0 = COL_YELLOW;
                else                         rgb_p0 = COL_RED;
            end
        end
    end

    // p0 -> p1: frame-rate state update and registered pixel colour
    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            shadow   <= '0;
            bar_h    <= '0;
            peak_h   <= '0;
            hold_cnt <= '0;
            rgb_p1   <= COL_BLACK;
        end else begin
            rgb_p1 <= rgb_p0;
            if (level_valid) shadow <= level;
            if (frame_start) begin
                bar_h <= new_h;
                if (new_h >= peak_h) begin
                    peak_h   <= new_h;
                    hold_cnt <= HCW'(HOLD_FRAMES);
                end else if (hold_cnt != '0) begin
                    hold_cnt <= hold_cnt - 1'b1;
                end else begin
                    peak_h <= decay_peak(peak_h, new_h);
                end
            end
        end
    end

    assign red   = rgb_p1[7:5];
    assign green = rgb_p1[4:2];
    assign blue  = rgb_p1[1:0];

endmodule

// File: tb/tb_vu_bar_renderer.sv
// Directed bench for vu_bar_renderer: expected colours queued per driven cycle, checked one clock later.
module tb_vu_bar_renderer;

    localparam logic [7:0] BLACK  = 8'h00;
    localparam logic [7:0] WHITE  = 8'hFF;
    localparam logic [7:0] GREEN  = 8'h1C;
    localparam logic [7:0] YELLOW = 8'hFC;
    localparam logic [7:0] RED    = 8'hE0;
    localparam int         COL    = 300;

    logic       pixel_clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] level = '0;
    logic       level_valid = 1'b0;
    logic [9:0] h_pos = '0;
    logic [9:0] v_pos = '0;
    logic       active = 1'b0;
    logic       frame_start = 1'b0;
    logic [2:0] red;
    logic [2:0] green;
    logic [1:0] blue;

    logic rst_drive = 1'b1;

    typedef struct {
        logic [7:0] exp;
        bit         chk;
        string      tag;
    } sb_entry_t;

    sb_entry_t sb[$];
    int checks = 0;
    int errors = 0;

    vu_bar_renderer dut (
        .pixel_clock (pixel_clock),
        .reset       (reset),
        .level       (level),
        .level_valid (level_valid),
        .h_pos       (h_pos),
        .v_pos       (v_pos),
        .active      (active),
        .frame_start (frame_start),
        .red         (red),
        .green       (green),
        .blue        (blue)
    );

    always #5 pixel_clock = ~pixel_clock;

    always @(posedge pixel_clock) begin
        sb_entry_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.chk) begin
                checks++;
                assert ({red, green, blue} === e.exp)
                else begin
                    errors++;
                    $error("FAIL %s observed %h expected %h", e.tag, {red, green, blue}, e.exp);
                end
            end
        end
    end

    task automatic step(input logic [9:0] h, input logic [9:0] v, input bit act,
                        input bit fs, input bit lv, input logic [7:0] lvl,
                        input logic [7:0] exp, input bit chk, input string tag);
        sb_entry_t e;
        @(negedge pixel_clock);
        reset       = rst_drive;
        h_pos       = h;
        v_pos       = v;
        active      = act;
        frame_start = fs;
        level_valid = lv;
        level       = lvl;
        e.exp = exp;
        e.chk = chk;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Pixel at column h, r rows from the bottom.
    task automatic pix(input int h, input int r, input logic [7:0] exp, input string tag);
        step(10'(h), 10'(479 - r), 1'b1, 1'b0, 1'b0, 8'd0, exp, 1'b1, tag);
    endtask

    task automatic strobe(input logic [7:0] lvl);
        step(10'd0, 10'd0, 1'b0, 1'b0, 1'b1, lvl, BLACK, 1'b1, "strobe");
    endtask

    task automatic frame();
        step(10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 8'd0, BLACK, 1'b1, "frame_start");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int pk;
        logic [7:0] e;

        // 1: reset held three cycles on a lit-capable pixel
        rst_drive = 1'b1;
        for (int i = 0; i < 3; i++) pix(COL, 10, BLACK, "reset_out");
        rst_drive = 1'b0;
        pix(COL, 0, BLACK, "post_reset_r0");
        pix(COL, 479, BLACK, "post_reset_r479");

        // 2: level 100 -> bar 200, peak marker rows 196..199
        strobe(8'd100);
        frame();
        for (int r = 0; r < 480; r++) begin
            e = (r >= 196 && r < 200) ? WHITE : (r < 196 ? GREEN : BLACK);
            pix(COL, r, e, "scan_l100");
        end
        step(10'(COL), 10'd480, 1'b1, 1'b0, 1'b0, 8'd0, BLACK, 1'b1, "v_out_of_range");
        step(10'd640, 10'd469, 1'b1, 1'b0, 1'b0, 8'd0, BLACK, 1'b1, "h_out_of_range");

        // 6: column edges and blanking
        pix(287, 10, BLACK, "col_287");
        pix(288, 10, GREEN, "col_288");
        pix(351, 10, GREEN, "col_351");
        pix(352, 10, BLACK, "col_352");
        step(10'(COL), 10'(479 - 10), 1'b0, 1'b0, 1'b0, 8'd0, BLACK, 1'b1, "inactive");
        pix(351, 198, WHITE, "col_351_peak");

        // 3: full scale clips at 480, colour zones
        strobe(8'd255);
        frame();
        pix(COL, 0, GREEN, "full_r0");
        pix(COL, 319, GREEN, "full_r319");
        pix(COL, 320, YELLOW, "full_r320");
        pix(COL, 419, YELLOW, "full_r419");
        pix(COL, 420, RED, "full_r420");
        pix(COL, 475, RED, "full_r475");
        for (int r = 476; r < 480; r++) pix(COL, r, WHITE, "full_peak");

        // 4: peak 200 held 30 frames then decays 4 rows per frame with bar at 0
        rst_drive = 1'b1;
        pix(COL, 0, BLACK, "reset_mid");
        rst_drive = 1'b0;
        strobe(8'd100);
        frame();
        pix(COL, 199, WHITE, "peak_set");
        strobe(8'd0);
        for (int k = 1; k <= 85; k++) begin
            frame();
            pk = (k <= 30) ? 200 : ((200 - 4 * (k - 30)) > 0 ? 200 - 4 * (k - 30) : 0);
            if (pk > 0) pix(COL, pk - 1, WHITE, "decay_peak_top");
            if (pk < 480) pix(COL, pk, BLACK, "decay_above_peak");
            pix(COL, 0, (pk >= 1 && pk <= 4) ? WHITE : BLACK, "decay_r0");
        end

        // 5: strobe coincident with frame_start lands one frame late
        strobe(8'd10);
        frame();
        pix(COL, 15, GREEN, "bar20_r15");
        pix(COL, 19, WHITE, "bar20_peak");
        pix(COL, 20, BLACK, "bar20_r20");
        step(10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 8'd50, BLACK, 1'b1, "fs_and_strobe");
        pix(COL, 15, GREEN, "same_r15");
        pix(COL, 16, WHITE, "same_peak");
        pix(COL, 20, BLACK, "same_r20");
        frame();
        pix(COL, 95, GREEN, "bar100_r95");
        pix(COL, 96, WHITE, "bar100_peak");
        pix(COL, 100, BLACK, "bar100_r100");

        // reset in the middle of a lit frame clears everything
        rst_drive = 1'b1;
        pix(COL, 50, BLACK, "reset_lit");
        rst_drive = 1'b0;
        pix(COL, 50, BLACK, "after_reset_r50");
        pix(COL, 0, BLACK, "after_reset_r0");
        frame();
        pix(COL, 0, BLACK, "after_reset_frame_r0");

        step(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 8'd0, BLACK, 1'b0, "drain");
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge pixel_clock);
        #2;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending %0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
